// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing (counters, syncs, bright, pixel/frame/game strobes).
// Latency: all decodes are registered from the next-count values, so they are aligned with hCount/vCount.
// Backpressure: none; the generator is free-running and its consumers must keep up every pixel.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst          synchronous active-low reset
//   hCount       horizontal position 0..H_TOTAL-1 (origin = start of hsync)
//   vCount       vertical position 0..V_TOTAL-1 (origin = start of vsync)
//   hSync/vSync  active-low sync pulses
//   bright       1 inside the visible window
//   pix_en       one-clock strobe after every counter advance
//   frame_start  one-clock strobe when the counters wrap to (0,0)
//   game_tick    one-clock strobe every GAME_DIV frames
//
// Build option: define VGA_GAME_TICK_EN to build the frame counter behind
// game_tick. Without it game_tick is tied low and GAME_DIV has no effect.

module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int GAME_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_en,
  output logic       frame_start,
  output logic       game_tick
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Region boundaries held at 11 bits so a total of exactly 1024 still fits;
  // the *_END values are exclusive.
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_BEG  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_END  = 11'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  // Elaboration-time parameter sanity checks.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       bright_q, bright_d;
  logic       pix_en_q;
  logic       frame_start_q;
  logic       adv;
  logic       line_end;
  logic       frame_end;
  logic [10:0] h_ext;
  logic [10:0] v_ext;

  always_comb begin
    adv       = (div_q == DIV_LAST);
    line_end  = adv && (h_q == H_LAST);
    frame_end = line_end && (v_q == V_LAST);

    // With CLK_DIV=1, DIV_LAST is 0 so div stays at 0 and every clock advances.
    div_d = adv ? 4'd0 : div_q + 4'd1;

    h_d = h_q;
    v_d = v_q;
    if (adv) begin
      h_d = line_end ? 10'd0 : h_q + 10'd1;
    end
    if (line_end) begin
      v_d = frame_end ? 10'd0 : v_q + 10'd1;
    end

    // Decode from the next counts so registered outputs line up with the counters.
    h_ext    = {1'b0, h_d};
    v_ext    = {1'b0, v_d};
    hsync_d  = (h_ext >= H_SYNC_END);
    vsync_d  = (v_ext >= V_SYNC_END);
    bright_d = (h_ext >= H_ACT_BEG) && (h_ext < H_ACT_END) &&
               (v_ext >= V_ACT_BEG) && (v_ext < V_ACT_END);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q         <= 4'd0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      bright_q      <= 1'b0;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      bright_q      <= bright_d;
      pix_en_q      <= adv;
      frame_start_q <= frame_end;
    end
  end

  assign hCount      = h_q;
  assign vCount      = v_q;
  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign bright      = bright_q;
  assign pix_en      = pix_en_q;
  assign frame_start = frame_start_q;

`ifdef VGA_GAME_TICK_EN
  localparam logic [7:0] FCNT_LAST = 8'(GAME_DIV - 1);

  if (GAME_DIV < 1 || GAME_DIV > 255) begin : g_bad_game_div
    $error("vga_timing_gen: GAME_DIV must be in 1..255");
  end

  logic [7:0] fcnt_q, fcnt_d;
  logic       tick_q, tick_d;

  // The tick is produced on the same edge as frame_start for the frame that
  // wraps fcnt, so both strobes coincide.
  always_comb begin
    fcnt_d = fcnt_q;
    tick_d = 1'b0;
    if (frame_end) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d = 8'd0;
        tick_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fcnt_q <= 8'd0;
      tick_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      tick_q <= tick_d;
    end
  end

  assign game_tick = tick_q;
`else
  logic unused_game_div;
  assign unused_game_div = (GAME_DIV == 0);
  assign game_tick       = 1'b0;
`endif

endmodule
